// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the stage bring-up sequencer.
package stage_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Width needed to hold a stage count in the range 0..n.
    function automatic int unsigned stage_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Active-low thermometer: bit i is 0 iff i < count; bits at or above width stay 1.
    function automatic logic [31:0] therm_n(input int unsigned count, input int unsigned width);
        logic [31:0] v;
        v = '1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < count && i < width) v[i] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Idle watchdog: counts enabled cycles and flags the cycle whose count would reach TIMEOUT.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;

    // Expiry is flagged combinationally so the sequencer leaves ST_RUN on the
    // very edge at which the count reaches TIMEOUT.
    assign expired_o = (TIMEOUT != 0) && count_en_i && (cnt_q == LIMIT);

    // Cycle counter; clear takes priority over counting.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Sequencer that enables downstream stages one at a time under a request/ack
// handshake, with rollback, request rejection and an idle watchdog.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned MODE_W     = 3,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned TO_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MODE_W-1:0]                 mode_num,
    input  logic                              mode_valid,
    input  logic [NUM_STAGES-1:0]             stage_done,
    output logic [NUM_STAGES-1:0]             enable_n,
    output logic [stage_w(NUM_STAGES)-1:0]    cur_stage,
    output logic                              req_ack,
    output logic                              req_nack,
    output logic                              all_en,
    output logic                              error
);

    localparam int unsigned   SW   = stage_w(NUM_STAGES);
    localparam int unsigned   CW   = (MODE_W > SW) ? MODE_W : SW;
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES);

    state_e                  state_q, state_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic [NUM_STAGES-1:0]   enable_n_q, enable_d;
    logic                    ack_q, ack_d;
    logic                    nack_q, nack_d;
    logic                    all_en_q, error_q;
    logic                    accept, done_sel;
    logic [CW-1:0]           m_c, s_c;
    logic                    wd_clear, wd_en, wd_expired;

    assign m_c = CW'(mode_num);
    assign s_c = CW'(stage_q);

    // Completion flag of the highest currently enabled stage (stage_q - 1).
    always_comb begin
        done_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (SW'(i + 1) == stage_q) done_sel = stage_done[i];
        end
    end

    // Next-state decision: request rules first, watchdog expiry only if no request was accepted.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                stage_d = SW'(1);
            end
            ST_RUN: begin
                if (mode_valid) begin
                    if (m_c == '0) begin
                        stage_d = SW'(1);
                        accept  = 1'b1;
                    end else if (m_c < s_c) begin
                        stage_d = SW'(mode_num);
                        accept  = 1'b1;
                    end else if (m_c == s_c && stage_q < LAST && done_sel) begin
                        stage_d = stage_q + SW'(1);
                        accept  = 1'b1;
                    end else begin
                        nack_d = 1'b1;
                    end
                end
                ack_d = accept;
                if (!accept && wd_expired) begin
                    state_d = ST_ERR;
                    stage_d = '0;
                end
            end
            ST_ERR: begin
                stage_d = '0;
                if (mode_valid) begin
                    if (m_c == '0) begin
                        ack_d   = 1'b1;
                        state_d = ST_INIT;
                    end else begin
                        nack_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                stage_d = '0;
            end
        endcase
        enable_d = NUM_STAGES'(therm_n(32'(stage_d), NUM_STAGES));
    end

    // Watchdog runs only while stages remain to be enabled; any non-RUN state
    // keeps it cleared so it starts from zero on entry to ST_RUN.
    assign wd_clear = (state_q != ST_RUN) || accept;
    assign wd_en    = (state_q == ST_RUN) && (stage_q < LAST);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (wd_clear),
        .count_en_i (wd_en),
        .expired_o  (wd_expired)
    );

    // Sequencer state and registered outputs; reset drops any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            stage_q    <= '0;
            enable_n_q <= '1;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            all_en_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            enable_n_q <= enable_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            all_en_q   <= (stage_d == LAST);
            error_q    <= (state_d == ST_ERR);
        end
    end

    assign enable_n  = enable_n_q;
    assign cur_stage = stage_q;
    assign req_ack   = ack_q;
    assign req_nack  = nack_q;
    assign all_en    = all_en_q;
    assign error     = error_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with a rule-level reference model.
module tb_stage_sequencer;

    localparam int N  = 5;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode_num = '0;
    logic       mode_valid = 1'b0;
    logic [4:0] stage_done = '0;
    logic [4:0] enable_n;
    logic [2:0] cur_stage;
    logic       req_ack, req_nack, all_en, error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_sequencer #(
        .NUM_STAGES (N),
        .MODE_W     (3),
        .TIMEOUT    (TO),
        .TO_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_num   (mode_num),
        .mode_valid (mode_valid),
        .stage_done (stage_done),
        .enable_n   (enable_n),
        .cur_stage  (cur_stage),
        .req_ack    (req_ack),
        .req_nack   (req_nack),
        .all_en     (all_en),
        .error      (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected active-low enables for s stages on.
    function automatic logic [4:0] exp_en(input int s);
        int full;
        full = (1 << N) - 1;
        return 5'(full & ~((1 << s) - 1));
    endfunction

    // Reference model: phase 0 = bring-up, 1 = running, 2 = fault.
    int m_ph = 0;
    int m_stage = 0;
    int m_cnt = 0;
    bit m_ack = 0;
    bit m_nack = 0;
    bit m_live = 0;

    always @(posedge clk) begin : model
        bit took;
        int m;
        m    = int'(mode_num);
        took = 0;
        if (rst) begin
            m_ph = 0; m_stage = 0; m_cnt = 0; m_ack = 0; m_nack = 0; m_live = 1;
        end else begin
            m_ack  = 0;
            m_nack = 0;
            if (m_ph == 0) begin
                m_ph = 1; m_stage = 1; m_cnt = 0;
            end else if (m_ph == 1) begin
                if (mode_valid) begin
                    if (m == 0) begin
                        m_stage = 1; took = 1;
                    end else if (m < m_stage) begin
                        m_stage = m; took = 1;
                    end else if (m == m_stage && m_stage < N && stage_done[m_stage-1]) begin
                        m_stage = m_stage + 1; took = 1;
                    end else begin
                        m_nack = 1;
                    end
                end
                if (took) begin
                    m_ack = 1; m_cnt = 0;
                end else if (m_stage < N) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt >= TO) begin
                        m_ph = 2; m_stage = 0; m_cnt = 0;
                    end
                end
            end else begin
                if (mode_valid) begin
                    if (m == 0) begin
                        m_ack = 1; m_ph = 0;
                    end else begin
                        m_nack = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_enable_n", 32'(enable_n),  32'(exp_en(m_stage)));
            chk("cmp_cur_stage", 32'(cur_stage), 32'(m_stage));
            chk("cmp_req_ack",  32'(req_ack),   32'(m_ack));
            chk("cmp_req_nack", 32'(req_nack),  32'(m_nack));
            chk("cmp_all_en",   32'(all_en),    32'(m_stage == N));
            chk("cmp_error",    32'(error),     32'(m_ph == 2));
        end
    end

    // Present one request for one cycle, then check the resulting pulse and enables.
    task automatic issue(input logic [2:0] m, input bit ack, input bit nack,
                         input logic [4:0] en, input string name);
        mode_valid = 1'b1;
        mode_num   = m;
        @(negedge clk);
        chk({name, "_ack"},  32'(req_ack),  32'(ack));
        chk({name, "_nack"}, 32'(req_nack), 32'(nack));
        chk({name, "_en"},   32'(enable_n), 32'(en));
    endtask

    task automatic idle(input int n);
        mode_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_enable_n", 32'(enable_n), 32'(5'b11111));
        chk("rst_cur_stage", 32'(cur_stage), 32'(0));
        chk("rst_pulses", 32'({req_ack, req_nack}), 32'(0));
        chk("rst_all_en_error", 32'({all_en, error}), 32'(0));

        rst = 1'b0;
        @(negedge clk);
        chk("release_enable_n", 32'(enable_n), 32'(5'b11110));
        chk("release_cur_stage", 32'(cur_stage), 32'(1));
        chk("release_pulses", 32'({req_ack, req_nack}), 32'(0));

        stage_done = 5'b11111;
        issue(3'd1, 1, 0, 5'b11100, "adv1");
        issue(3'd2, 1, 0, 5'b11000, "adv2");
        issue(3'd3, 1, 0, 5'b10000, "adv3");
        issue(3'd4, 1, 0, 5'b00000, "adv4");
        chk("adv_all_en", 32'(all_en), 32'(1));
        issue(3'd5, 0, 1, 5'b00000, "adv_past_end");
        chk("adv_past_end_stage", 32'(cur_stage), 32'(5));

        issue(3'd2, 1, 0, 5'b11100, "rollback");
        issue(3'd0, 1, 0, 5'b11110, "restart");

        issue(3'd1, 1, 0, 5'b11100, "to_stage2");
        stage_done = 5'b11101;
        issue(3'd2, 0, 1, 5'b11100, "gated");
        issue(3'd4, 0, 1, 5'b11100, "skip_ahead");
        issue(3'd7, 0, 1, 5'b11100, "out_of_range");
        stage_done = 5'b11111;
        issue(3'd2, 1, 0, 5'b11000, "ungated");
        chk("ungated_stage", 32'(cur_stage), 32'(3));

        rst = 1'b1;
        issue(3'd3, 0, 0, 5'b11111, "mid_reset");
        chk("mid_reset_stage", 32'(cur_stage), 32'(0));
        chk("mid_reset_all_en_error", 32'({all_en, error}), 32'(0));
        rst = 1'b0;
        idle(1);
        chk("mid_reset_release", 32'(cur_stage), 32'(1));

        idle(15);
        chk("wd_not_yet", 32'(error), 32'(0));
        idle(1);
        chk("wd_expired", 32'(error), 32'(1));
        chk("wd_enable_n", 32'(enable_n), 32'(5'b11111));
        chk("wd_cur_stage", 32'(cur_stage), 32'(0));

        issue(3'd3, 0, 1, 5'b11111, "err_reject");
        chk("err_reject_sticky", 32'(error), 32'(1));
        issue(3'd0, 1, 0, 5'b11111, "err_clear");
        chk("err_clear_error", 32'(error), 32'(0));
        issue(3'd3, 0, 0, 5'b11110, "init_ignores");
        chk("init_ignores_stage", 32'(cur_stage), 32'(1));

        idle(15);
        issue(3'd1, 1, 0, 5'b11100, "wd_tie");
        chk("wd_tie_error", 32'(error), 32'(0));
        idle(15);
        chk("wd_cleared_by_ack", 32'(error), 32'(0));
        issue(3'd2, 1, 0, 5'b11000, "top_adv2");
        issue(3'd3, 1, 0, 5'b10000, "top_adv3");
        issue(3'd4, 1, 0, 5'b00000, "top_adv4");
        idle(40);
        chk("hold_at_top_error", 32'(error), 32'(0));
        chk("hold_at_top_all_en", 32'(all_en), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
